mem_request_queue: RTL and testbench

Bounded in-order request queue between the trace parser and the DRAM command scheduler. It captures each parsed operation (opcode and address) when the parser presents it and holds up to DEPTH outstanding requests. It presents the oldest request to the scheduler together with its age in cycles, and back-pressures the parser when full.

---
 rtl/global_defs.sv | 24 ++
 rtl/mem_request_queue.sv | 145 ++++++++++++++
 tb/tb_mem_request_queue.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/global_defs.sv
// Shared definitions for the trace-replay memory path.
//   parsed_op_t    : opcode produced by the trace parser (NOP = no operation)
//   queue_states_t : occupancy state of mem_request_queue
//   ADDRESS_WIDTH  : width of every request address
//   QUEUE_DEPTH    : default number of entries in mem_request_queue
package global_defs;

    localparam int ADDRESS_WIDTH = 32;
    localparam int QUEUE_DEPTH   = 16;

    typedef enum logic [1:0] {
        NOP    = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        IFETCH = 2'd3
    } parsed_op_t;

    typedef enum logic [1:0] {
        Q_EMPTY  = 2'd0,
        Q_ACTIVE = 2'd1,
        Q_FULL   = 2'd2
    } queue_states_t;

endpackage

// File: rtl/mem_request_queue.sv
// Bounded in-order request queue between the trace parser and the DRAM
// command scheduler. Holds up to DEPTH requests in a circular buffer and
// presents the oldest one together with the number of cycles it has waited.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : parser offers a request (NOPs are accepted and dropped)
//   in_opcode     : opcode of the offered request
//   in_address    : address of the offered request
//   in_ready      : queue can accept (== !full)
//   out_valid     : head entry present (== !empty)
//   out_opcode    : head opcode, NOP when empty
//   out_address   : head address, 0 when empty
//   out_age       : cycles the head has been resident (saturating), 0 when empty
//   out_ready     : scheduler consumes the head this cycle
//   occupancy     : number of valid entries
//   full, empty   : occupancy == DEPTH / occupancy == 0
//   state         : debug view of the occupancy FSM
module mem_request_queue
    import global_defs::*;
#(
    parameter int DEPTH     = QUEUE_DEPTH,
    parameter int AGE_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  parsed_op_t                    in_opcode,
    input  logic [ADDRESS_WIDTH-1:0]      in_address,
    output logic                          in_ready,
    output logic                          out_valid,
    output parsed_op_t                    out_opcode,
    output logic [ADDRESS_WIDTH-1:0]      out_address,
    output logic [AGE_WIDTH-1:0]          out_age,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic                          full,
    output logic                          empty,
    output queue_states_t                 state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    logic [PTR_W-1:0]         wr_ptr_reg;
    logic [PTR_W-1:0]         rd_ptr_reg;
    logic [OCC_W-1:0]         occupancy_reg;
    logic [OCC_W-1:0]         occupancy_next;
    queue_states_t            state_reg;

    parsed_op_t               op_mem   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
    logic [AGE_WIDTH-1:0]     age_reg  [DEPTH];
    logic                     valid_reg[DEPTH];

    logic enq;
    logic deq;

    // Status flags come straight from the occupancy register, so nothing on
    // in_* or out_ready reaches any output combinationally.
    assign full      = (occupancy_reg == OCC_W'(DEPTH));
    assign empty     = (occupancy_reg == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign occupancy = occupancy_reg;
    assign state     = state_reg;

    // NOPs are acknowledged (in_ready still high) but never stored.
    assign enq = in_valid && !full && (in_opcode != NOP);
    assign deq = !empty && out_ready;

    always_comb begin
        occupancy_next = occupancy_reg;
        case ({enq, deq})
            2'b10:   occupancy_next = occupancy_reg + OCC_W'(1);
            2'b01:   occupancy_next = occupancy_reg - OCC_W'(1);
            default: occupancy_next = occupancy_reg;
        endcase
    end

    // Pointers, occupancy and the occupancy FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            occupancy_reg <= '0;
            state_reg     <= Q_EMPTY;
        end else begin
            // Pointer width is log2(DEPTH), so the increment wraps by itself.
            if (enq) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (deq) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            occupancy_reg <= occupancy_next;

            case (state_reg)
                Q_EMPTY: begin
                    if (enq) state_reg <= Q_ACTIVE;
                end
                Q_ACTIVE: begin
                    if (occupancy_next == OCC_W'(DEPTH))
                        state_reg <= Q_FULL;
                    else if (occupancy_next == '0)
                        state_reg <= Q_EMPTY;
                end
                Q_FULL: begin
                    if (deq) state_reg <= Q_ACTIVE;
                end
                default: state_reg <= Q_EMPTY;
            endcase
        end
    end

    // Payload storage carries no reset: validity is tracked separately and
    // the head outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            op_mem[wr_ptr_reg]   <= in_opcode;
            addr_mem[wr_ptr_reg] <= in_address;
        end
    end

    // Per-entry valid flag and saturating age counter. An entry can never be
    // written and consumed in the same cycle: wr_ptr == rd_ptr only when the
    // queue is empty (no dequeue) or full (no enqueue).
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg[gi] <= 1'b0;
                age_reg[gi]   <= '0;
            end else if (enq && (wr_ptr_reg == PTR_W'(gi))) begin
                valid_reg[gi] <= 1'b1;
                age_reg[gi]   <= '0;
            end else if (deq && (rd_ptr_reg == PTR_W'(gi))) begin
                valid_reg[gi] <= 1'b0;
            end else if (valid_reg[gi] && (age_reg[gi] != AGE_MAX)) begin
                age_reg[gi] <= age_reg[gi] + AGE_WIDTH'(1);
            end
        end
    end

    assign out_opcode  = empty ? NOP : op_mem[rd_ptr_reg];
    assign out_address = empty ? '0  : addr_mem[rd_ptr_reg];
    assign out_age     = empty ? '0  : age_reg[rd_ptr_reg];

endmodule

// File: tb/tb_mem_request_queue.sv
module tb_mem_request_queue;
    import global_defs::*;

    localparam int DEPTH     = 16;
    localparam int AGE_WIDTH = 4;
    localparam int AGE_SAT   = (1 << AGE_WIDTH) - 1;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    parsed_op_t               in_opcode;
    logic [ADDRESS_WIDTH-1:0] in_address;
    logic                     in_ready;
    logic                     out_valid;
    parsed_op_t               out_opcode;
    logic [ADDRESS_WIDTH-1:0] out_address;
    logic [AGE_WIDTH-1:0]     out_age;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   occupancy;
    logic                     full;
    logic                     empty;
    queue_states_t            state;

    mem_request_queue #(.DEPTH(DEPTH), .AGE_WIDTH(AGE_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_opcode  (in_opcode),
        .in_address (in_address),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_opcode (out_opcode),
        .out_address(out_address),
        .out_age    (out_age),
        .out_ready  (out_ready),
        .occupancy  (occupancy),
        .full       (full),
        .empty      (empty),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a FIFO of requests stamped with the cycle they were
    // accepted; age is simply "cycles since acceptance", clipped.
    typedef struct {
        parsed_op_t  op;
        logic [31:0] addr;
        int          enq_cyc;
    } req_t;

    req_t mq[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_addr;
        int          e_age;
        parsed_op_t  e_op;
        queue_states_t e_state;
        int          n;
        n = mq.size();
        if (n == 0) begin
            e_op = NOP; e_addr = 0; e_age = 0;
        end else begin
            e_op   = mq[0].op;
            e_addr = mq[0].addr;
            e_age  = cyc - mq[0].enq_cyc;
            if (e_age > AGE_SAT) e_age = AGE_SAT;
        end
        e_state = (n == 0) ? Q_EMPTY : ((n == DEPTH) ? Q_FULL : Q_ACTIVE);
        chk({tag, ".out_valid"},   32'(out_valid),   32'(n != 0));
        chk({tag, ".out_opcode"},  32'(out_opcode),  32'(e_op));
        chk({tag, ".out_address"}, out_address,      e_addr);
        chk({tag, ".out_age"},     32'(out_age),     32'(e_age));
        chk({tag, ".occupancy"},   32'(occupancy),   32'(n));
        chk({tag, ".full"},        32'(full),        32'(n == DEPTH));
        chk({tag, ".empty"},       32'(empty),       32'(n == 0));
        chk({tag, ".in_ready"},    32'(in_ready),    32'(n != DEPTH));
        chk({tag, ".state"},       32'(state),       32'(e_state));
    endtask

    // One clock cycle: drive inputs, let the model decide what fires from
    // its own contents, advance at the edge, then compare after the edge.
    task automatic step(input string tag, input logic v, input parsed_op_t op,
                        input logic [31:0] addr, input logic rdy);
        bit do_enq, do_deq;
        req_t r;
        in_valid   = v;
        in_opcode  = op;
        in_address = addr;
        out_ready  = rdy;
        do_enq = v && (mq.size() < DEPTH) && (op != NOP);
        do_deq = rdy && (mq.size() > 0);
        @(posedge clk);
        cyc++;
        if (do_deq) void'(mq.pop_front());
        if (do_enq) begin
            r.op = op; r.addr = addr; r.enq_cyc = cyc;
            mq.push_back(r);
        end
        #1;
        check_all(tag);
        $display("[%0t] %s v=%0d op=%0d addr=0x%0h rdy=%0d -> occ=%0d head=0x%0h age=%0d",
                 $time, tag, v, op, addr, rdy, occupancy, out_address, out_age);
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        check_all(tag);
        $display("[%0t] %s reset asserted -> occ=%0d", $time, tag, occupancy);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        parsed_op_t rop;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_opcode  = NOP;
        in_address = '0;
        out_ready  = 1'b0;

        // Reset applied between edges: outputs must settle before any edge.
        #1 rst = 1'b1;
        #1;
        check_all("reset_idle");
        $display("[%0t] reset_idle occ=%0d state=%0d", $time, occupancy, state);
        #1 rst = 1'b0;

        // Single request and age growth.
        step("single_enq", 1'b1, READ, 32'h1F00, 1'b0);
        chk("single_age0", 32'(out_age), 32'd0);
        for (int i = 0; i < 5; i++) step("single_hold", 1'b0, NOP, 32'h0, 1'b0);
        chk("single_age5", 32'(out_age), 32'd5);
        step("single_deq", 1'b0, NOP, 32'h0, 1'b1);
        chk("single_empty", 32'(empty), 32'd1);

        // Fill, reject a 17th, then wrap the pointers.
        for (int i = 0; i < DEPTH; i++) begin
            rop = parsed_op_t'($urandom_range(1, 3));
            step("fill", 1'b1, rop, 32'(i), 1'b0);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_state", 32'(state), 32'(Q_FULL));
        step("fill_17th", 1'b1, READ, 32'd99, 1'b0);
        chk("fill_17th_occ", 32'(occupancy), 32'(DEPTH));
        for (int i = 0; i < 4; i++) step("wrap_deq", 1'b0, NOP, 32'h0, 1'b1);
        for (int i = 16; i < 20; i++) step("wrap_enq", 1'b1, WRITE, 32'(i), 1'b0);
        chk("wrap_head", out_address, 32'd4);
        for (int i = 0; i < DEPTH; i++) step("wrap_drain", 1'b0, NOP, 32'h0, 1'b1);

        // Steady state at occupancy 3 with enqueue and dequeue every cycle.
        for (int i = 0; i < 3; i++) step("sim_pre", 1'b1, READ, 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 10; i++) step("sim_both", 1'b1, IFETCH, 32'h200 + 32'(i), 1'b1);
        chk("sim_occ", 32'(occupancy), 32'd3);
        for (int i = 0; i < 3; i++) step("sim_drain", 1'b0, NOP, 32'h0, 1'b1);

        // NOP filtering.
        step("nop_w", 1'b1, WRITE, 32'h10, 1'b0);
        step("nop_n", 1'b1, NOP, 32'h15, 1'b0);
        step("nop_i", 1'b1, IFETCH, 32'h20, 1'b0);
        chk("nop_occ", 32'(occupancy), 32'd2);
        step("nop_drain", 1'b0, NOP, 32'h0, 1'b1);
        step("nop_head", 1'b0, NOP, 32'h0, 1'b0);
        chk("nop_second", out_address, 32'h20);
        step("nop_drain", 1'b0, NOP, 32'h0, 1'b1);

        // Age saturation, then reset with 7 entries resident.
        step("sat_enq", 1'b1, READ, 32'hABC, 1'b0);
        for (int i = 0; i < 20; i++) step("sat_hold", 1'b0, NOP, 32'h0, 1'b0);
        chk("sat_age", 32'(out_age), 32'(AGE_SAT));
        for (int i = 0; i < 6; i++) step("pre_rst", 1'b1, WRITE, 32'h300 + 32'(i), 1'b0);
        chk("pre_rst_occ", 32'(occupancy), 32'd7);
        pulse_reset("mid_rst");
        chk("mid_rst_occ", 32'(occupancy), 32'd0);

        // Random traffic, first biased toward filling, then toward draining.
        for (int i = 0; i < 400; i++) begin
            logic v, rdy;
            v   = ($urandom_range(0, 3) != 0);
            rdy = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            rop = parsed_op_t'($urandom_range(0, 3));
            step("rand", v, rop, $urandom, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
